// File: rtl/pc_sequencer.sv
// Fetch/PC controller for the two-stage FETCH -> EX/WB core: owns the
// instruction-RAM address, tracks the EX slot, squashes on redirect and runs the debug FSM.
module pc_sequencer #(
  parameter int                  PC_WIDTH = 12,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                stall_req,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  input  logic                halt_req,
  input  logic                resume,
  input  logic                step,
  output logic [PC_WIDTH-1:0] pc_fetch,
  output logic                fetch_en,
  output logic [PC_WIDTH-1:0] pc_ex,
  output logic                ex_valid,
  output logic                halted,
  output logic [1:0]          state,
  output logic [31:0]         retired_count
);

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    HALT       = 2'd1,
    STEP_FETCH = 2'd2,
    STEP_EXEC  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_fetch_d, pc_ex_d, pc_inc;
  logic                ex_valid_d;
  logic                done;
  logic                hold;

  assign done   = ex_valid && !stall_req;
  assign hold   = ex_valid && stall_req;
  assign pc_inc = pc_fetch + PC_WIDTH'(1);
  assign state  = state_q;
  assign halted = (state_q == HALT);

  // NOTE: every signal driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    pc_fetch_d = pc_fetch;
    pc_ex_d    = pc_ex;
    ex_valid_d = ex_valid;
    fetch_en   = 1'b0;

    unique case (state_q)
      RUN: begin
        fetch_en = !hold;
        if (hold) begin
          // Redirect and halt wait until the multi-cycle instruction completes.
        end else if (halt_req) begin
          // pc_fetch already names the next unexecuted instruction.
          if (done && redirect_valid) pc_fetch_d = redirect_target;
          ex_valid_d = 1'b0;
          state_d    = HALT;
        end else if (done && redirect_valid) begin
          pc_fetch_d = redirect_target;
          pc_ex_d    = pc_fetch;
          ex_valid_d = 1'b0;
        end else begin
          pc_ex_d    = pc_fetch;
          pc_fetch_d = pc_inc;
          ex_valid_d = 1'b1;
        end
      end

      HALT: begin
        if (step)        state_d = STEP_FETCH;
        else if (resume) state_d = RUN;
      end

      STEP_FETCH: begin
        fetch_en   = 1'b1;
        pc_ex_d    = pc_fetch;
        pc_fetch_d = pc_inc;
        ex_valid_d = 1'b1;
        state_d    = STEP_EXEC;
      end

      STEP_EXEC: begin
        if (done) begin
          if (redirect_valid) pc_fetch_d = redirect_target;
          ex_valid_d = 1'b0;
          state_d    = HALT;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      pc_fetch      <= RESET_PC;
      pc_ex         <= '0;
      ex_valid      <= 1'b0;
      retired_count <= '0;
    end else begin
      state_q  <= state_d;
      pc_fetch <= pc_fetch_d;
      pc_ex    <= pc_ex_d;
      ex_valid <= ex_valid_d;
      if (done) retired_count <= retired_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: straight-line fetch, redirect,
// PC wrap, stall with deferred redirect, halt/resume, single-step and async reset.
module tb_pc_sequencer;

  localparam int PW = 12;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          stall_req, redirect_valid, halt_req, resume, step;
  logic [PW-1:0] redirect_target;
  logic [PW-1:0] pc_fetch, pc_ex;
  logic          fetch_en, ex_valid, halted;
  logic [1:0]    state;
  logic [31:0]   retired_count;

  int n_checks = 0;
  int n_fail   = 0;

  pc_sequencer #(.PC_WIDTH(PW), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_req      (stall_req),
    .redirect_valid (redirect_valid),
    .redirect_target(redirect_target),
    .halt_req       (halt_req),
    .resume         (resume),
    .step           (step),
    .pc_fetch       (pc_fetch),
    .fetch_en       (fetch_en),
    .pc_ex          (pc_ex),
    .ex_valid       (ex_valid),
    .halted         (halted),
    .state          (state),
    .retired_count  (retired_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  always @(posedge clk)
    if (rst_n && redirect_valid && !ex_valid)
      $display("protocol error: redirect_valid with ex_valid=0 at %0t", $time);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // pe < 0 means pc_ex is a don't-care (bubble in EX).
  task automatic expect_core(input string tag, input int pf, input int pe, input int ev,
                             input int st, input int ret);
    check({tag, ".pc_fetch"}, 32'(pc_fetch), 32'(pf));
    if (pe >= 0) check({tag, ".pc_ex"}, 32'(pc_ex), 32'(pe));
    check({tag, ".ex_valid"}, 32'(ex_valid), 32'(ev));
    check({tag, ".state"}, 32'(state), 32'(st));
    check({tag, ".halted"}, 32'(halted), (st == 1) ? 32'd1 : 32'd0);
    check({tag, ".retired"}, retired_count, 32'(ret));
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after an edge: pulse reset between edges, then run n edges.
  task automatic restart(input int n);
    stall_req = 0; redirect_valid = 0; halt_req = 0; resume = 0; step = 0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick(n);
  endtask

  initial begin
    rst_n = 1'b0;
    stall_req = 0; redirect_valid = 0; halt_req = 0; resume = 0; step = 0;
    redirect_target = '0;

    // Reset values
    #1;
    expect_core("reset", 0, 0, 0, 0, 0);
    check("reset.fetch_en", 32'(fetch_en), 32'd1);

    // Straight-line fetch
    #2 rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      expect_core($sformatf("line%0d", k), k, k - 1, 1, 0, k - 1);
    end

    // Redirect from pc_ex = 3 to 0x40, then redirect to 0xFFF to exercise the wrap
    restart(4);
    expect_core("redir.pre", 4, 3, 1, 0, 3);
    redirect_valid = 1; redirect_target = 12'h040;
    tick();
    expect_core("redir.bubble", 12'h040, -1, 0, 0, 4);
    redirect_valid = 0;
    tick();
    expect_core("redir.target", 12'h041, 12'h040, 1, 0, 4);
    redirect_valid = 1; redirect_target = 12'hFFF;
    tick();
    expect_core("wrap.bubble", 12'hFFF, -1, 0, 0, 5);
    redirect_valid = 0;
    tick();
    expect_core("wrap.top", 0, 12'hFFF, 1, 0, 5);
    tick();
    expect_core("wrap.zero", 1, 0, 1, 0, 6);

    // Stall with redirect held; redirect takes effect on the completing edge
    restart(6);
    expect_core("stall.pre", 6, 5, 1, 0, 5);
    stall_req = 1; redirect_valid = 1; redirect_target = 12'h010;
    #1;
    check("stall.fetch_en", 32'(fetch_en), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_core($sformatf("stall%0d", k), 6, 5, 1, 0, 5);
    end
    stall_req = 0;
    tick();
    expect_core("stall.release", 12'h010, -1, 0, 0, 6);
    redirect_valid = 0;
    tick();
    expect_core("stall.target", 12'h011, 12'h010, 1, 0, 6);

    // Halt at pc_ex = 7, stay frozen, resume
    restart(8);
    expect_core("halt.pre", 8, 7, 1, 0, 7);
    halt_req = 1;
    tick();
    expect_core("halt.enter", 8, -1, 0, 1, 8);
    check("halt.fetch_en", 32'(fetch_en), 32'd0);
    halt_req = 0;
    tick(10);
    expect_core("halt.frozen", 8, -1, 0, 1, 8);
    resume = 1;
    tick();
    expect_core("resume.edge1", 8, -1, 0, 0, 8);
    resume = 0;
    tick();
    expect_core("resume.edge2", 9, 8, 1, 0, 8);

    // Single step twice from HALT at pc_fetch = 8
    restart(8);
    halt_req = 1;
    tick();
    halt_req = 0;
    expect_core("step.halted", 8, -1, 0, 1, 8);
    for (int s = 0; s < 2; s++) begin
      step = 1;
      tick();
      step = 0;
      expect_core($sformatf("step%0d.fetch", s), 8 + s, -1, 0, 2, 8 + s);
      check($sformatf("step%0d.fetch_en", s), 32'(fetch_en), 32'd1);
      tick();
      expect_core($sformatf("step%0d.exec", s), 9 + s, 8 + s, 1, 3, 8 + s);
      check($sformatf("step%0d.exec_fetch_en", s), 32'(fetch_en), 32'd0);
      tick();
      expect_core($sformatf("step%0d.done", s), 9 + s, -1, 0, 1, 9 + s);
      tick();
    end

    // Reset asynchronously while stalled in STEP_EXEC
    step = 1;
    tick();
    step = 0;
    stall_req = 1;
    tick();
    expect_core("rststall.exec", 11, 10, 1, 3, 10);
    tick();
    expect_core("rststall.held", 11, 10, 1, 3, 10);
    #3;
    rst_n = 1'b0;
    #1;
    expect_core("rststall.reset", 0, 0, 0, 0, 0);
    stall_req = 0;
    #1 rst_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Fetch/PC controller for the two-stage FETCH→EX/WB RISC-V core. Owns the instruction-RAM read address, tracks validity and PC of the instruction in EX, and handles taken-branch/jump redirects with one-bubble squash. Also handles EX stalls from multi-cycle units and a debug halt/resume/single-step FSM. Replaces the free-running PC increment in the CPU top level; the control unit gates regwrite and GPIO write-enable with `ex_valid`.

Parameters:
- PC_WIDTH, 12, width of the instruction-RAM word address.
- RESET_PC, 0, word address fetched first after reset.

Ports:
- clk, input, 1, core clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- stall_req, input, 1, EX instruction not finished; hold pipeline.
- redirect_valid, input, 1, EX instruction is a taken branch or jump.
- redirect_target, input, PC_WIDTH, word address of the redirect destination.
- halt_req, input, 1, debug halt request (level).
- resume, input, 1, leave HALT (level, sampled in HALT only).
- step, input, 1, execute exactly one instruction from HALT.
- pc_fetch, output, PC_WIDTH, instruction-RAM read address; RAM data lands in the EX register on the next edge when `fetch_en` = 1.
- fetch_en, output, 1, load enable for the EX instruction register (combinational).
- pc_ex, output, PC_WIDTH, PC of the instruction currently in EX.
- ex_valid, output, 1, EX holds an instruction that must take effect; 0 means bubble.
- halted, output, 1, state == HALT.
- state, output, 2, FSM state: RUN=0, HALT=1, STEP_FETCH=2, STEP_EXEC=3.
- retired_count, output, 32, instructions retired since reset; wraps modulo 2^32.

Behaviour:
- Reset (async, rst_n = 0): pc_fetch = RESET_PC, pc_ex = 0, ex_valid = 0, state = RUN, retired_count = 0.
- done = ex_valid && !stall_req. Retirement = done; retired_count increments by 1 on each retiring edge.
- The redirect_valid and halt_req inputs are honoured only per the rules below. A redirect_valid with ex_valid = 0 is ignored; the bench flags it as a protocol error.
- fetch_en = 1 in RUN unless (stall_req && ex_valid); = 1 in STEP_FETCH; = 0 in HALT and STEP_EXEC.
- RUN, priority highest first:
  1. stall_req && ex_valid: hold pc_fetch, pc_ex and ex_valid. Redirect and halt are deferred until done.
  2. halt_req: pc_fetch holds (it already points at the next unexecuted instruction). If done, that instruction retires and redirect is applied to pc_fetch. ex_valid ← 0, state ← HALT.
  3. done && redirect_valid: pc_fetch ← redirect_target; pc_ex ← old pc_fetch; ex_valid ← 0, squashing the wrong-path fetch. Penalty is exactly 1 bubble.
  4. Otherwise: pc_ex ← pc_fetch, pc_fetch ← pc_fetch + 1 (wraps at 2^PC_WIDTH), ex_valid ← 1.
- HALT:
  - All registers hold.
  - step has priority over resume.
  - step → state ← STEP_FETCH.
  - resume → state ← RUN, ex_valid stays 0; the first post-resume instruction is valid in EX 2 edges after resume is sampled.
- STEP_FETCH: pc_ex ← pc_fetch, pc_fetch ← pc_fetch + 1, ex_valid ← 1, state ← STEP_EXEC.
- STEP_EXEC:
  - Hold while stall_req.
  - On done: retire; apply redirect to pc_fetch if redirect_valid; ex_valid ← 0; state ← HALT.
  - halt_req, resume and step are ignored in this state.
- Reset mid-operation (any state, any stall) returns immediately to the reset values; no retirement is counted for the aborted instruction.
- pc_ex is meaningful only while ex_valid = 1.

Test Plan:
- Straight-line: release reset, no stimulus, 5 edges → pc_fetch 0,1,2,3,4,5; ex_valid 0 then 1; pc_ex 0..4; retired_count = 4.
- Redirect: with pc_ex = 3, assert redirect_valid, target = 0x40 for 1 cycle → next edge: pc_fetch = 0x40, ex_valid = 0. Following edge: pc_ex = 0x40, ex_valid = 1. retired_count is unchanged by the bubble.
- Stall + redirect: pc_ex = 5 with stall_req high for 3 cycles and redirect_valid, target = 0x10 held throughout → pc_fetch stays 6 for 3 cycles. On the first edge with stall_req low: pc_fetch = 0x10, ex_valid = 0, retired_count + 1.
- Halt/resume: assert halt_req when pc_ex = 7 → HALT with pc_fetch = 8, halted = 1, ex_valid = 0; counters frozen for 10 cycles. Pulse resume → pc_ex = 8 valid 2 edges later.
- Single step: from HALT at pc_fetch = 8, pulse step twice (spaced 4 cycles apart) → state sequence 2,3,1 each time; pc_ex = 8 then 9; retired_count + 2; pc_fetch = 10.
- Reset mid-stall: in STEP_EXEC with stall_req = 1, drop rst_n asynchronously between edges → outputs reach reset values before the next clock edge; state = RUN, retired_count = 0.
